// File: rtl/upsize_rr_arbiter.sv
// upsize_rr_arbiter: round-robin share of a 2:1 width upsizer, pair-locked grants, owner tag tracking
module upsize_rr_arbiter #(
    parameter int N   = 4,
    parameter int W   = 40,
    parameter int IDW = $clog2(N)
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic [N*W-1:0] req_tdata,
    input  logic [N-1:0]   req_tvalid,
    output logic [N-1:0]   req_tready,
    output logic [W-1:0]   up_tdata,
    output logic           up_tvalid,
    input  logic           up_tready,
    input  logic           out_tvalid,
    input  logic           out_tready,
    output logic [IDW-1:0] out_tid,
    output logic           tag_err
);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] sel_q, sel_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] tag_q [2];
    logic           head_q, head_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           tag_err_q, tag_err_d;
    logic [IDW-1:0] pick_base, pick;
    logic           any_valid, tag_not_full, beat_en, accept, push, push_ok, pop;

    function automatic logic [IDW-1:0] wrap(input int v);
        return IDW'(v >= N ? v - N : v);
    endfunction

    assign any_valid    = |req_tvalid;
    assign tag_not_full = cnt_q != 2'd2;
    assign beat_en      = (state_q == BEAT0) || (state_q == BEAT1 && tag_not_full);
    assign accept       = up_tvalid && up_tready;
    assign push         = state_q == BEAT1 && accept;
    assign push_ok      = push && tag_not_full;
    assign pop          = out_tvalid && out_tready && cnt_q != 2'd0;

    // Round-robin search starting after the pointer; in BEAT1 the current owner becomes lowest priority
    always_comb begin
        pick_base = (state_q == BEAT1) ? sel_q : rr_ptr_q;
        pick      = '0;
        for (int k = N; k >= 1; k--)
            if (req_tvalid[wrap(int'(pick_base) + k)]) pick = wrap(int'(pick_base) + k);
    end

    // State register: FSM, grant owner and round-robin pointer
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= IDW'(N - 1);
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next state: grant held for two beats, re-arbitrate on the second accept with no bubble
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: if (any_valid) begin
                sel_d   = pick;
                state_d = BEAT0;
            end
            BEAT0: if (accept) state_d = BEAT1;
            BEAT1: if (accept) begin
                rr_ptr_d = sel_q;
                sel_d    = pick;
                state_d  = any_valid ? BEAT0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: mux the owner onto the upsizer; the second beat waits for tag space
    always_comb begin
        up_tdata   = req_tdata[int'(sel_q)*W +: W];
        up_tvalid  = beat_en && req_tvalid[sel_q];
        req_tready = (beat_en && up_tready) ? {{(N-1){1'b0}}, 1'b1} << sel_q : '0;
        out_tid    = cnt_q != 2'd0 ? tag_q[head_q] : '0;
        tag_err    = tag_err_q;
    end

    // Tag queue bookkeeping: pop advances the head, push lands behind whatever survives
    always_comb begin
        cnt_d     = cnt_q + 2'(push_ok) - 2'(pop);
        head_d    = head_q ^ pop;
        tag_err_d = tag_err_q || (push && !tag_not_full);
    end

    // Tag queue storage, occupancy and sticky overflow flag
    always_ff @(posedge aclk) begin
        if (areset) begin
            tag_q[0]  <= '0;
            tag_q[1]  <= '0;
            head_q    <= 1'b0;
            cnt_q     <= 2'd0;
            tag_err_q <= 1'b0;
        end else begin
            if (push_ok) tag_q[head_q ^ cnt_q[0]] <= sel_q;
            head_q    <= head_d;
            cnt_q     <= cnt_d;
            tag_err_q <= tag_err_d;
        end
    end
endmodule
